shift_unit: RTL and testbench

SHIFT_UNIT -- requirements
Module: shift_unit

---
 rtl/shift_pkg.sv | 22 ++
 rtl/shift_step.sv | 33 +++
 rtl/shift_unit.sv | 115 +++++++++++
 tb/tb_shift_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift unit: op encodings, FSM states
// and the shift-amount width helper.
package shift_pkg;

    typedef enum logic [1:0] {
        OpSll = 2'b00,
        OpSrl = 2'b01,
        OpSra = 2'b10,
        OpRor = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    function automatic int unsigned shamt_w(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single step: shifts or rotates a value right/left by 0..STEP bits.
module shift_step import shift_pkg::*; #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4,
    localparam int unsigned AMT_W = $clog2(STEP + 1)
) (
    input  op_e              op,
    input  logic             fill,
    input  logic [WIDTH-1:0] value,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] out
);

    logic [2*WIDTH-1:0] wide;

    always_comb begin
        out  = value;
        wide = {value, value};
        unique case (op)
            OpSll: out = value << amt;
            OpSrl: out = value >> amt;
            OpSra, OpRor: begin
                // Upper half supplies the incoming bits: sign fill or the value itself.
                if (op == OpSra) begin
                    wide = {{WIDTH{fill}}, value};
                end
                wide = wide >> amt;
                out  = wide[WIDTH-1:0];
            end
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shifter: walks the shift amount down by at most STEP bits per cycle
// and publishes the registered result with a one-cycle done pulse.
module shift_unit import shift_pkg::*; #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 op,
    input  logic [WIDTH-1:0]           src,
    input  logic [shamt_w(WIDTH)-1:0]  shamt,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           result,
    output logic                       zero
);

    localparam int unsigned SHAMT_W = shamt_w(WIDTH);
    localparam int unsigned AMT_W   = $clog2(STEP + 1);
    localparam logic [SHAMT_W:0] STEP_LIM = (SHAMT_W + 1)'(STEP);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   val_q, val_d;
    op_e                op_q, op_d;
    logic               fill_q, fill_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;

    logic [SHAMT_W:0]   rem_ext;
    logic [AMT_W-1:0]   k;
    logic [SHAMT_W-1:0] rem_left;
    logic [WIDTH-1:0]   step_out;

    assign rem_ext  = {1'b0, rem_q};
    assign k        = (rem_ext < STEP_LIM) ? AMT_W'(rem_q) : AMT_W'(STEP);
    assign rem_left = SHAMT_W'(rem_ext - (SHAMT_W + 1)'(k));

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .op    (op_q),
        .fill  (fill_q),
        .value (val_q),
        .amt   (k),
        .out   (step_out)
    );

    always_comb begin
        state_d  = state_q;
        val_d    = val_q;
        op_d     = op_q;
        fill_d   = fill_q;
        rem_d    = rem_q;
        result_d = result_q;
        zero_d   = zero_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    val_d  = src;
                    op_d   = op_e'(op);
                    fill_d = src[WIDTH-1];
                    rem_d  = shamt;
                    if (shamt != '0) begin
                        state_d = StShift;
                    end else begin
                        // Zero-length shift publishes the operand directly.
                        state_d  = StDone;
                        result_d = src;
                        zero_d   = (src == '0);
                    end
                end
            end
            StShift: begin
                val_d = step_out;
                rem_d = rem_left;
                if (rem_left == '0) begin
                    state_d  = StDone;
                    result_d = step_out;
                    zero_d   = (step_out == '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            val_q    <= '0;
            op_q     <= OpSll;
            fill_q   <= 1'b0;
            rem_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            val_q    <= val_d;
            op_q     <= op_d;
            fill_q   <= fill_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q == StShift);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: scoreboarded operations on a 32/4 instance
// plus a 16/1 instance for the single-bit-step configuration.
module tb_shift_unit;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src = '0;
    logic [4:0]  shamt = '0;
    logic        busy, done, zero;
    logic [31:0] result;

    logic        n_start = 1'b0;
    logic [1:0]  n_op = 2'b00;
    logic [15:0] n_src = '0;
    logic [3:0]  n_shamt = '0;
    logic        n_busy, n_done, n_zero;
    logic [15:0] n_result;

    shift_unit #(.WIDTH(32), .STEP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src(src), .shamt(shamt),
        .busy(busy), .done(done), .result(result), .zero(zero)
    );

    shift_unit #(.WIDTH(16), .STEP(1)) dut_n (
        .clk(clk), .rst(rst), .start(n_start), .op(n_op), .src(n_src), .shamt(n_shamt),
        .busy(n_busy), .done(n_done), .result(n_result), .zero(n_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] s,
                                            input int a);
        logic [31:0] r;
        case (o)
            2'b00:   r = s << a;
            2'b01:   r = s >> a;
            2'b10:   r = $signed(s) >>> a;
            default: r = (s >> a) | (s << (32 - a));
        endcase
        return r;
    endfunction

    task automatic push_const(input logic [31:0] r, input logic z, input int lat);
        exp_t e;
        e.res = r; e.zero = z; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic push_model(input logic [1:0] o, input logic [31:0] s, input int a);
        exp_t e;
        e.res  = ref_res(o, s, a);
        e.zero = (e.res == 32'h0);
        e.lat  = 1 + (a + S - 1) / S;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (or after bound).
    // poke_kind 1 raises start with junk operands, 2 raises rst, at cycle t0+poke_off.
    task automatic do_op(input logic [1:0] o, input logic [31:0] s, input logic [4:0] a,
                         input int poke_off, input int poke_kind, input int bound,
                         output bit seen, output logic [31:0] r, output logic z,
                         output int lat, output int busy_cnt);
        int t0;
        op = o; src = s; shamt = a; start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0; lat = -1; busy_cnt = 0;
        for (int i = 0; i < bound; i++) begin
            if (done) begin
                seen = 1'b1; lat = cyc - t0; r = result; z = zero;
                break;
            end
            if (busy) busy_cnt++;
            if (poke_kind == 1 && cyc == t0 + poke_off) begin
                start = 1'b1; op = 2'b01; src = 32'hFFFF_FFFF; shamt = 5'd1;
            end else if (poke_kind == 2 && cyc == t0 + poke_off) begin
                rst = 1'b1;
            end else begin
                start = 1'b0; rst = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; rst = 1'b0;
        if (!seen) begin
            r = result; z = zero;
        end
    endtask

    task automatic test_reset();
        start = 1'b1; op = 2'b00; src = 32'h1; shamt = 5'd3;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, result, zero} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b result=%h zero=%b, want 0 0 0 1",
                     busy, done, result, zero);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_priority: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_ops();
        logic [1:0]  t_op[5]  = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b01};
        logic [31:0] t_src[5] = '{32'h1, 32'h8000_0000, 32'h1234_5678, 32'hDEAD_BEEF, 32'hF};
        logic [4:0]  t_sh[5]  = '{5'd31, 5'd4, 5'd8, 5'd0, 5'd4};
        logic [31:0] t_res[5] = '{32'h8000_0000, 32'hF800_0000, 32'h7812_3456,
                                  32'hDEAD_BEEF, 32'h0};
        logic        t_z[5]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          t_lat[5] = '{9, 2, 3, 1, 2};
        for (int i = 0; i < 13; i++) begin
            logic [1:0]  o;
            logic [31:0] s, r;
            logic [4:0]  a;
            logic        z;
            bit          seen;
            int          lat, bc;
            exp_t        e;
            if (i < 5) begin
                o = t_op[i]; s = t_src[i]; a = t_sh[i];
                push_const(t_res[i], t_z[i], t_lat[i]);
            end else begin
                o = 2'($urandom_range(0, 3)); s = $urandom; a = 5'($urandom_range(0, 31));
                push_model(o, s, int'(a));
            end
            do_op(o, s, a, 0, 0, 40, seen, r, z, lat, bc);
            e = sb.pop_front();
            n_checks++;
            if (lat !== e.lat) begin
                n_fail++;
                $display("FAIL op%0d_latency: got %0d, want %0d", i, lat, e.lat);
            end
            n_checks++;
            if (r !== e.res) begin
                n_fail++;
                $display("FAIL op%0d_result: got %h, want %h", i, r, e.res);
            end
            n_checks++;
            if (z !== e.zero) begin
                n_fail++;
                $display("FAIL op%0d_zero: got %b, want %b", i, z, e.zero);
            end
            n_checks++;
            if (bc !== e.lat - 1) begin
                n_fail++;
                $display("FAIL op%0d_busy_cycles: got %0d, want %0d", i, bc, e.lat - 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] r;
        logic        z;
        bit          seen;
        int          lat, bc;
        exp_t        e;
        push_const(32'h8000_0000, 1'b0, 9);
        do_op(2'b00, 32'h1, 5'd31, 3, 1, 40, seen, r, z, lat, bc);
        e = sb.pop_front();
        n_checks++;
        if ({lat, r, z} !== {e.lat, e.res, e.zero}) begin
            n_fail++;
            $display("FAIL ignore_start: lat=%0d result=%h zero=%b, want %0d %h %b",
                     lat, r, z, e.lat, e.res, e.zero);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({done, result} !== {1'b0, 32'h8000_0000}) begin
            n_fail++;
            $display("FAIL result_hold: done=%b result=%h, want 0 80000000", done, result);
        end
    endtask

    task automatic test_abort();
        logic [31:0] r;
        logic        z;
        bit          seen;
        int          lat, bc;
        do_op(2'b00, 32'h1, 5'd31, 3, 2, 15, seen, r, z, lat, bc);
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: done seen=%b, want 0", seen);
        end
        n_checks++;
        if ({busy, result, zero} !== {1'b0, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b result=%h zero=%b, want 0 0 1",
                     busy, result, zero);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  t_op[3]  = '{2'b11, 2'b10, 2'b01};
        logic [31:0] t_src[3] = '{32'h1234_5678, 32'h8000_0000, 32'hDEAD_BEEF};
        logic [4:0]  t_sh[3]  = '{5'd8, 5'd4, 5'd0};
        for (int i = 0; i < 3; i++) push_model(t_op[i], t_src[i], int'(t_sh[i]));
        for (int i = 0; i < 3; i++) begin
            logic [31:0] r;
            logic        z;
            bit          seen;
            int          lat, bc;
            exp_t        e;
            do_op(t_op[i], t_src[i], t_sh[i], 0, 0, 40, seen, r, z, lat, bc);
            e = sb.pop_front();
            n_checks++;
            if ({lat, r, z} !== {e.lat, e.res, e.zero}) begin
                n_fail++;
                $display("FAIL b2b%0d: lat=%0d result=%h zero=%b, want %0d %h %b",
                         i, lat, r, z, e.lat, e.res, e.zero);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_narrow();
        int   t0, lat, bc;
        exp_t e;
        push_const(32'h0000_8000, 1'b0, 16);
        n_op = 2'b00; n_src = 16'h0001; n_shamt = 4'd15; n_start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        n_start = 1'b0;
        lat = -1; bc = 0;
        for (int i = 0; i < 40; i++) begin
            if (n_done) begin
                lat = cyc - t0;
                break;
            end
            if (n_busy) bc++;
            @(negedge clk);
        end
        e = sb.pop_front();
        n_checks++;
        if ({lat, 16'h0, n_result, n_zero} !== {e.lat, e.res, e.zero}) begin
            n_fail++;
            $display("FAIL narrow_sll: lat=%0d result=%h zero=%b, want %0d %h %b",
                     lat, n_result, n_zero, e.lat, e.res[15:0], e.zero);
        end
        n_checks++;
        if (bc !== 15) begin
            n_fail++;
            $display("FAIL narrow_busy_cycles: got %0d, want 15", bc);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_ops();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_narrow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
